// File: rtl/bram_arb_pkg.sv
// Shared definitions for the block-RAM port arbiter: default widths, master ids
// and the read-tag record that follows a read through the RAM latency.
package bram_arb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  localparam logic M_IFETCH = 1'b0;
  localparam logic M_LSU    = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage : bram_arb_pkg

// File: rtl/rd_tag_pipe.sv
// Delay line for read tags, RD_LATENCY stages deep, so each tag leaves the pipe
// in the same cycle its data appears on the RAM output.
module rd_tag_pipe
  import bram_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t r_stage [RD_LATENCY];
  rd_tag_t w_stage_in [RD_LATENCY];

  genvar gi;
  generate
    for (gi = 0; gi < RD_LATENCY; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign w_stage_in[gi] = i_tag;
      end else begin : g_tail
        assign w_stage_in[gi] = r_stage[gi-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_stage[gi] <= '0;
        end else begin
          r_stage[gi] <= w_stage_in[gi];
        end
      end
    end
  endgenerate

  assign o_tag = r_stage[RD_LATENCY-1];

endmodule : rd_tag_pipe

// File: rtl/bram_port_arbiter.sv
// Round-robin sharing of one single-port block RAM between instruction fetch (m0)
// and the load/store unit (m1); read data is steered back with a per-master strobe.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W     = bram_arb_pkg::ADDR_W,
  parameter int DATA_W     = bram_arb_pkg::DATA_W,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  logic    r_last_gnt;
  logic    w_gnt0;
  logic    w_gnt1;
  rd_tag_t w_tag_in;
  rd_tag_t w_tag_out;

  // On contention the master that did not win last time goes first.
  assign w_gnt0 = rst_n & m0_req & (~m1_req | (r_last_gnt == M_LSU));
  assign w_gnt1 = rst_n & m1_req & (~m0_req | (r_last_gnt == M_IFETCH));

  assign m0_gnt = w_gnt0;
  assign m1_gnt = w_gnt1;

  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (w_gnt0) begin
      ram_en   = 1'b1;
      ram_we   = m0_we;
      ram_addr = m0_addr;
      ram_din  = m0_wdata;
    end else if (w_gnt1) begin
      ram_en   = 1'b1;
      ram_we   = m1_we;
      ram_addr = m1_addr;
      ram_din  = m1_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_gnt <= M_LSU;
    end else if (w_gnt0) begin
      r_last_gnt <= M_IFETCH;
    end else if (w_gnt1) begin
      r_last_gnt <= M_LSU;
    end
  end

  assign w_tag_in.valid = ram_en & ~ram_we;
  assign w_tag_in.id    = w_gnt1 ? M_LSU : M_IFETCH;

  rd_tag_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_rd_tag_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .i_tag(w_tag_in),
    .o_tag(w_tag_out)
  );

  assign m0_rvalid = rst_n & w_tag_out.valid & (w_tag_out.id == M_IFETCH);
  assign m1_rvalid = rst_n & w_tag_out.valid & (w_tag_out.id == M_LSU);
  assign m0_rdata  = ram_dout;
  assign m1_rdata  = ram_dout;

endmodule : bram_port_arbiter

// File: tb/tb_bram_port_arbiter.sv
// Two arbiter instances (read latency 1 and 2) share one stimulus stream and are
// compared every cycle against a transaction-level model of the shared RAM port.
module tb_bram_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [7:0]  m0_addr = 0, m1_addr = 0;
  logic [31:0] m0_wdata = 0, m1_wdata = 0;

  logic g0_a, g1_a, rv0_a, rv1_a, en_a, we_a;
  logic g0_b, g1_b, rv0_b, rv1_b, en_b, we_b;
  logic [7:0]  addr_a, addr_b;
  logic [31:0] rd0_a, rd1_a, din_a, dout_a, rd0_b, rd1_b, din_b, dout_b;

  bram_port_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LATENCY(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(g0_a), .m1_gnt(g1_a), .m0_rvalid(rv0_a), .m1_rvalid(rv1_a),
    .m0_rdata(rd0_a), .m1_rdata(rd1_a),
    .ram_en(en_a), .ram_we(we_a), .ram_addr(addr_a), .ram_din(din_a), .ram_dout(dout_a));

  bram_port_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LATENCY(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(g0_b), .m1_gnt(g1_b), .m0_rvalid(rv0_b), .m1_rvalid(rv1_b),
    .m0_rdata(rd0_b), .m1_rdata(rd1_b),
    .ram_en(en_b), .ram_we(we_b), .ram_addr(addr_b), .ram_din(din_b), .ram_dout(dout_b));

  function automatic logic [31:0] init_val(input logic [7:0] i);
    return (i == 8'h05) ? 32'hDEADBEEF : {8'hC3, i, ~i, i ^ 8'h5A};
  endfunction

  // RAM instances: latency 1 (no output register) and latency 2 (output register on).
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] q_a1 = 0, q_b1 = 0, q_b2 = 0;
  bit preloaded = 0;
  assign dout_a = q_a1;
  assign dout_b = q_b2;

  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= init_val(i[7:0]);
        mem_b[i] <= init_val(i[7:0]);
      end
      preloaded <= 1;
    end else begin
      if (en_a) begin
        if (we_a) mem_a[addr_a] <= din_a;
        else      q_a1 <= mem_a[addr_a];
      end
      if (en_b) begin
        if (we_b) mem_b[addr_b] <= din_b;
        else      q_b1 <= mem_b[addr_b];
      end
      q_b2 <= q_b1;
    end
  end

  // Reference model: memory image, round-robin history, pending read returns.
  typedef struct {
    int          due;
    bit          id;
    logic [31:0] data;
  } exp_t;

  logic [31:0] ref_mem [256];
  exp_t q_exp_a[$];
  exp_t q_exp_b[$];
  int   last_id = 1;
  int   cyc = 0;
  bit   rst_drive = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_port(input string p, input logic g0, g1, en, we,
                            input logic [7:0] addr, input logic [31:0] din,
                            input logic rv0, rv1, input logic [31:0] rd0, rd1,
                            input bit eg0, eg1, ewe, input logic [7:0] ea,
                            input logic [31:0] ed, input bit hit, input exp_t h);
    chk({p, "_m0_gnt"}, {31'b0, g0}, {31'b0, eg0});
    chk({p, "_m1_gnt"}, {31'b0, g1}, {31'b0, eg1});
    chk({p, "_ram_en"}, {31'b0, en}, {31'b0, eg0 | eg1});
    chk({p, "_ram_we"}, {31'b0, we}, {31'b0, ewe});
    chk({p, "_ram_addr"}, {24'b0, addr}, {24'b0, ea});
    chk({p, "_ram_din"}, din, ed);
    chk({p, "_m0_rvalid"}, {31'b0, rv0}, {31'b0, hit && !h.id});
    chk({p, "_m1_rvalid"}, {31'b0, rv1}, {31'b0, hit && h.id});
    if (hit) chk({p, "_rdata"}, h.id ? rd1 : rd0, h.data);
  endtask

  task automatic step(input bit r0, w0, input logic [7:0] a0, input logic [31:0] d0,
                      input bit r1, w1, input logic [7:0] a1, input logic [31:0] d1,
                      output bit g0, output bit g1);
    bit eg0, eg1, ewe, hit_a, hit_b;
    logic [7:0] ea;
    logic [31:0] ed;
    exp_t ha, hb;
    @(negedge clk);
    rst_n = rst_drive;
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    #1;
    if (!rst_drive) begin
      q_exp_a.delete();
      q_exp_b.delete();
      last_id = 1;
    end
    eg0 = 0; eg1 = 0;
    if (rst_drive) begin
      if (r0 && r1) begin
        eg0 = (last_id == 1);
        eg1 = !eg0;
      end else begin
        eg0 = r0;
        eg1 = r1;
      end
    end
    ewe = eg0 ? w0 : (eg1 ? w1 : 1'b0);
    ea  = eg0 ? a0 : (eg1 ? a1 : 8'h0);
    ed  = eg0 ? d0 : (eg1 ? d1 : 32'h0);
    ha = '{0, 0, 0};
    hb = '{0, 0, 0};
    hit_a = (q_exp_a.size() > 0) && (q_exp_a[0].due == cyc);
    hit_b = (q_exp_b.size() > 0) && (q_exp_b[0].due == cyc);
    if (hit_a) ha = q_exp_a.pop_front();
    if (hit_b) hb = q_exp_b.pop_front();
    check_port("L1", g0_a, g1_a, en_a, we_a, addr_a, din_a, rv0_a, rv1_a, rd0_a, rd1_a,
               eg0, eg1, ewe, ea, ed, hit_a, ha);
    check_port("L2", g0_b, g1_b, en_b, we_b, addr_b, din_b, rv0_b, rv1_b, rd0_b, rd1_b,
               eg0, eg1, ewe, ea, ed, hit_b, hb);
    if (eg0 || eg1) begin
      last_id = eg1 ? 1 : 0;
      if (ewe) begin
        ref_mem[ea] = ed;
      end else begin
        q_exp_a.push_back('{cyc + 1, eg1, ref_mem[ea]});
        q_exp_b.push_back('{cyc + 2, eg1, ref_mem[ea]});
      end
    end
    $display("cyc=%0d rst_n=%0b req=%0b%0b gnt=%0b%0b we=%0b addr=%h rv_a=%0b%0b rv_b=%0b%0b",
             cyc, rst_drive, r0, r1, eg0, eg1, ewe, ea, rv0_a, rv1_a, rv0_b, rv1_b);
    cyc++;
    g0 = eg0;
    g1 = eg1;
  endtask

  task automatic idle(input int n);
    bit x0, x1;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, x0, x1);
  endtask

  initial begin
    bit g0, g1;
    bit p0_req, p0_we, p1_req, p1_we;
    logic [7:0]  p0_addr, p1_addr;
    logic [31:0] p0_data, p1_data;
    int i0, i1;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i[7:0]);

    rst_drive = 0;
    idle(2);
    rst_drive = 1;

    // Single read of the preloaded word.
    step(1, 0, 8'h05, 0, 0, 0, 0, 0, g0, g1);
    chk("t1_gnt_same_cycle", {31'b0, g0_a}, 32'd1);
    idle(1);
    chk("t1_rvalid", {31'b0, rv0_a}, 32'd1);
    chk("t1_rdata", rd0_a, 32'hDEADBEEF);
    chk("t1_m1_rvalid", {31'b0, rv1_a}, 32'd0);
    idle(2);

    // Continuous contention straight after reset: m0,m1,m0,m1,m0,m1.
    rst_drive = 0; idle(1); rst_drive = 1;
    i0 = 0; i1 = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 8'h10 + 8'(i0), 0, 1, 0, 8'h20 + 8'(i1), 0, g0, g1);
      chk("rr_alternate", {31'b0, g0_a}, {31'b0, (i % 2) == 0});
      if (g0) i0++;
      if (g1) i1++;
    end
    idle(3);

    // Write by m1 followed immediately by a read of the same word by m0.
    step(0, 0, 0, 0, 1, 1, 8'h03, 32'h5, g0, g1);
    step(1, 0, 8'h03, 0, 0, 0, 0, 0, g0, g1);
    idle(1);
    chk("raw_rdata", rd0_a, 32'h5);
    idle(2);

    // m1 held while m0 wins, then served the next cycle with its command intact.
    step(0, 0, 0, 0, 1, 0, 8'h40, 0, g0, g1);
    step(1, 0, 8'h41, 0, 1, 1, 8'h42, 32'hA5A5_0042, g0, g1);
    chk("hold_m0_first", {31'b0, g0}, 32'd1);
    step(0, 0, 0, 0, 1, 1, 8'h42, 32'hA5A5_0042, g0, g1);
    chk("hold_m1_next", {31'b0, g1_a}, 32'd1);
    chk("hold_addr", {24'b0, addr_a}, 32'h42);
    idle(3);

    // Reset asserted the cycle after a read grant discards that read.
    step(1, 0, 8'h07, 0, 0, 0, 0, 0, g0, g1);
    rst_drive = 0;
    step(1, 0, 8'h08, 0, 1, 0, 8'h09, 0, g0, g1);
    chk("rst_no_rvalid_L1", {31'b0, rv0_a}, 32'd0);
    chk("rst_no_gnt", {31'b0, g0_b | g1_b}, 32'd0);
    idle(1);
    rst_drive = 1;
    idle(2);
    step(1, 0, 8'h0A, 0, 1, 0, 8'h0B, 0, g0, g1);
    chk("post_rst_m0_wins", {31'b0, g0_a}, 32'd1);
    idle(3);

    // Randomised traffic honouring the hold-until-granted rule.
    p0_req = 0; p1_req = 0;
    p0_we = 0; p1_we = 0; p0_addr = 0; p1_addr = 0; p0_data = 0; p1_data = 0;
    for (int n = 0; n < 400; n++) begin
      if (!p0_req && $urandom_range(0, 99) < 65) begin
        p0_req = 1; p0_we = ($urandom_range(0, 3) == 0);
        p0_addr = 8'($urandom_range(0, 15)); p0_data = $urandom;
      end
      if (!p1_req && $urandom_range(0, 99) < 65) begin
        p1_req = 1; p1_we = ($urandom_range(0, 2) == 0);
        p1_addr = 8'($urandom_range(0, 15)); p1_data = $urandom;
      end
      rst_drive = ($urandom_range(0, 99) != 0);
      step(p0_req, p0_we, p0_addr, p0_data, p1_req, p1_we, p1_addr, p1_data, g0, g1);
      if (g0) p0_req = 0;
      if (g1) p1_req = 0;
    end
    rst_drive = 1;
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_bram_port_arbiter

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Round-robin arbiter sharing the single-port data block RAM (`blk_mem_gen_0`, 8-bit address, 32-bit data) between two requesters: master 0 (instruction fetch) and master 1 (load/store unit). It multiplexes one granted access per cycle onto the RAM port. It then routes read data back to the issuing master after the RAM read latency, tagged with a valid strobe. It sits between the core's memory interfaces and the RAM instance.

## Interface
- `ADDR_W`, 8, RAM word-address width (matches `addra`).
- `DATA_W`, 32, RAM data width (matches `dina`/`douta`).
- `RD_LATENCY`, 1, cycles from granted read to valid `ram_dout`; legal values 1 or 2 (2 = RAM output register enabled).
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `m0_req`, `m1_req`  in  1  access request; held with its command until granted.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  ADDR_W  word address.
- `m0_wdata`, `m1_wdata`  in  DATA_W  write data.
- `m0_gnt`, `m1_gnt`  out  1  request accepted this cycle (combinational).
- `m0_rvalid`, `m1_rvalid`  out  1  read data valid for this master this cycle.
- `m0_rdata`, `m1_rdata`  out  DATA_W  read data (= `ram_dout`, meaningful only with rvalid).
- `ram_en`  out  1  to `ena`.
- `ram_we`  out  1  to `wea`.
- `ram_addr`  out  ADDR_W  to `addra`.
- `ram_din`  out  DATA_W  to `dina`.
- `ram_dout`  in  DATA_W  from `douta`.

## Operation
- Arbitration each cycle. With no requests, no grant is issued and `ram_en`=0. With exactly one `mX_req`, that master is granted. With both, the master not granted most recently is granted.
- `last_gnt` register updates only on a cycle with a grant. Reset value = 1, so master 0 wins the first contention.
- On grant: `ram_en`=1, and `ram_we`/`ram_addr`/`ram_din` are driven from the granted master's `we`/`addr`/`wdata`. With no grant, all RAM outputs are 0.
- Writes complete on the granting edge; no rvalid is generated for a write.
- Reads push a tag {valid, master_id} into a RD_LATENCY-deep shift pipe. When the tag exits, the matching `mX_rvalid`=1 for one cycle.
- Fully pipelined: a new grant is allowed every cycle, including back-to-back reads from alternating masters. Rvalids return in issue order.
- The requester must hold `req`, `we`, `addr`, `wdata` stable until it sees `gnt`. It may deassert `req` after the granting edge or issue the next request immediately.
- No backpressure on rvalid; the master must accept its data in the rvalid cycle.
- Read-after-write to the same address on consecutive grants returns the written value. The RAM is configured WRITE_FIRST/READ_FIRST irrelevant because the accesses are in different cycles.
- Reset (asynchronous, any time):
  - Tag pipe cleared and `last_gnt`=1.
  - While `rst_n`=0: all gnt, rvalid, `ram_en` and `ram_we` are 0, gated combinationally.
  - Reads in flight at reset never produce rvalid.

## Timing
- Grant latency: 0 cycles (combinational from req); an uncontended request is granted in its first cycle.
- Read data: a read granted at edge N has `mX_rvalid`=1 in the cycle after edge N+RD_LATENCY-1, aligned with valid `ram_dout`.
- Worst-case wait under continuous contention: 1 cycle.
- Write: takes effect at the granting edge.
- Reset values: `last_gnt`=1, tag pipe all invalid. All outputs are 0, except `rdata`, which follows `ram_dout`.

## Structure
- Package `bram_arb_pkg`:
  - defaults `ADDR_W`, `DATA_W`
  - master-id constants `M_IFETCH`=0, `M_LSU`=1
  - packed typedef `rd_tag_t` {valid, id}.
- Sub-module `rd_tag_pipe`: parameterised RD_LATENCY shift register of `rd_tag_t` with async active-low clear.
- The arbiter top holds the round-robin logic and muxes.

## Test plan
- Reset with RD_LATENCY=1: m0 read addr 0x05 (RAM preloaded 0xDEADBEEF) → `m0_gnt` same cycle, `m0_rvalid`=1 with `m0_rdata`=0xDEADBEEF exactly one cycle later; `m1_rvalid` stays 0.
- Both request continuously for 6 cycles (m0 reads 0x10.., m1 reads 0x20..) → grants alternate m0,m1,m0,m1,m0,m1. Each rvalid goes to the right master with the correct data, one cycle after its grant.
- m1 writes 0x00000005 to 0x03, then m0 reads 0x03 the next cycle → `m0_rdata`=0x00000005.
- m1 holds a request while m0 is granted → m1 is granted the following cycle. Its addr/wdata hold is honored and the `ram_addr` sequence matches.
- RD_LATENCY=2 back-to-back reads → rvalids arrive 2 cycles after each grant, in order, with no bubbles.
- Assert `rst_n`=0 one cycle after a read grant → no rvalid ever appears for it. After release, the first contended grant goes to m0.
